// File: rtl/uart_fifo_pkg.sv
// Shared types and width helpers for the UART transmit FIFO path.
package uart_fifo_pkg;

  typedef enum logic [1:0] {IDLE, WAIT_BUSY, WAIT_IDLE} tx_state_t;

  function automatic int ptr_w(input int depth);
    return $clog2(depth);
  endfunction

  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/sync_fifo_mem.sv
// DATA_W x DEPTH storage: synchronous write, registered read that doubles as the launch data register.
module sync_fifo_mem import uart_fifo_pkg::*; #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int PTR_W  = ptr_w(DEPTH)
) (
  input  logic              clock,
  input  logic              rst,
  input  logic              we,
  input  logic [PTR_W-1:0]  waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [PTR_W-1:0]  raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clock) begin
    if (we) mem[waddr] <= wdata;
  end

  // Only loaded on a launch, so rdata holds the last launched byte.
  always_ff @(posedge clock) begin
    if (rst)     rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/uart_tx_fifo_ctrl.sv
// Transmit-side FIFO and TI-handshake sequencer: buffers host bytes and releases
// them one per WR strobe, with overflow/timeout reporting, flush and watermark.
module uart_tx_fifo_ctrl import uart_fifo_pkg::*; #(
  parameter int DATA_W   = 8,
  parameter int DEPTH    = 16,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int EDGE_WR  = 1,
  parameter int BUSY_TO  = 1023
) (
  input  logic                      clock,
  input  logic                      rst,
  input  logic                      en,
  input  logic [DATA_W-1:0]         din,
  input  logic                      flush,
  input  logic                      clr_err,
  input  logic                      TI,
  output logic                      WR,
  output logic [DATA_W-1:0]         dout,
  output logic                      full,
  output logic                      empty,
  output logic                      almost_full,
  output logic [cnt_w(DEPTH)-1:0]   count,
  output logic                      overflow,
  output logic                      timeout
);

  localparam int PTR_W  = ptr_w(DEPTH);
  localparam int CNT_W  = cnt_w(DEPTH);
  localparam int TCNT_W = (BUSY_TO > 1) ? $clog2(BUSY_TO) : 1;
  localparam logic [TCNT_W-1:0] TO_LAST = TCNT_W'((BUSY_TO > 0) ? BUSY_TO - 1 : 0);

  logic              en_s1, en_s2;
  logic              push_req, push, pop;
  logic [PTR_W-1:0]  wptr, rptr;
  logic [TCNT_W-1:0] tcnt;
  tx_state_t         state;

  assign push_req    = (EDGE_WR != 0) ? (en_s1 & ~en_s2) : en_s1;
  assign push        = push_req & ~full & ~flush;
  assign pop         = (state == IDLE) & TI & ~empty;
  assign full        = (count == CNT_W'(DEPTH));
  assign empty       = (count == '0);
  assign almost_full = (count >= CNT_W'(AF_LEVEL));

  always_ff @(posedge clock) begin
    if (rst) begin
      en_s1 <= 1'b0;
      en_s2 <= 1'b0;
    end else begin
      en_s1 <= en;
      en_s2 <= en_s1;
    end
  end

  // Flush clears occupancy only; a pop on the same edge still launches its byte.
  always_ff @(posedge clock) begin
    if (rst) begin
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (flush) begin
        wptr  <= '0;
        rptr  <= '0;
        count <= '0;
      end else begin
        if (push) wptr <= wptr + PTR_W'(1);
        if (pop)  rptr <= rptr + PTR_W'(1);
        if (push && !pop)      count <= count + CNT_W'(1);
        else if (!push && pop) count <= count - CNT_W'(1);
      end
      if (clr_err)         overflow <= 1'b0;
      if (push_req && full) overflow <= 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      state   <= IDLE;
      WR      <= 1'b0;
      tcnt    <= '0;
      timeout <= 1'b0;
    end else begin
      WR <= 1'b0;
      if (clr_err) timeout <= 1'b0;
      case (state)
        IDLE: if (pop) begin
          WR    <= 1'b1;
          tcnt  <= '0;
          state <= WAIT_BUSY;
        end
        WAIT_BUSY: begin
          if (!TI) state <= WAIT_IDLE;
          else if (BUSY_TO != 0 && tcnt == TO_LAST) begin
            timeout <= 1'b1;
            state   <= IDLE;
          end else tcnt <= tcnt + TCNT_W'(1);
        end
        WAIT_IDLE: if (TI) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  sync_fifo_mem #(.DATA_W(DATA_W), .DEPTH(DEPTH), .PTR_W(PTR_W)) u_mem (
    .clock (clock),
    .rst   (rst),
    .we    (push),
    .waddr (wptr),
    .wdata (din),
    .re    (pop),
    .raddr (rptr),
    .rdata (dout)
  );

endmodule

// File: tb/tb_uart_tx_fifo_ctrl.sv
// Bench for uart_tx_fifo_ctrl: edge-mode instance with BUSY_TO=8 plus a level-mode instance.
module tb_uart_tx_fifo_ctrl;

  typedef struct {
    logic [7:0] din;
    logic [4:0] cnt;
    logic       full;
    logic       af;
    logic       ovf;
    logic       kept;
  } vec_t;

  logic       clock, rst, en, flush, clr_err, ti_man, ti_model, auto_ti, TI;
  logic [7:0] din, dout;
  logic       WR, full, empty, af, ovf, tmo;
  logic [4:0] count;

  logic       en_l, flush_l, clr_l, ti_l;
  logic [7:0] din_l, dout_l;
  logic       wr_l, full_l, empty_l, af_l, ovf_l, tmo_l;
  logic [4:0] cnt_l;

  int         n_vec = 0, n_miss = 0, n_wr = 0, base, bcnt;
  logic       wr_prev = 1'b0;
  logic [7:0] sb[$];
  vec_t       tbl[17];

  assign TI = auto_ti ? ti_model : ti_man;

  uart_tx_fifo_ctrl #(.DATA_W(8), .DEPTH(16), .AF_LEVEL(14), .EDGE_WR(1), .BUSY_TO(8)) u_dut (
    .clock(clock), .rst(rst), .en(en), .din(din), .flush(flush), .clr_err(clr_err), .TI(TI),
    .WR(WR), .dout(dout), .full(full), .empty(empty), .almost_full(af), .count(count),
    .overflow(ovf), .timeout(tmo)
  );

  uart_tx_fifo_ctrl #(.DATA_W(8), .DEPTH(16), .AF_LEVEL(14), .EDGE_WR(0), .BUSY_TO(0)) u_lvl (
    .clock(clock), .rst(rst), .en(en_l), .din(din_l), .flush(flush_l), .clr_err(clr_l), .TI(ti_l),
    .WR(wr_l), .dout(dout_l), .full(full_l), .empty(empty_l), .almost_full(af_l), .count(cnt_l),
    .overflow(ovf_l), .timeout(tmo_l)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // UART model: TI falls the cycle after WR, stays low two more cycles, then rises.
  always @(posedge clock) begin
    if (!auto_ti || rst) begin
      ti_model <= 1'b1;
      bcnt     <= 0;
    end else if (WR) begin
      ti_model <= 1'b0;
      bcnt     <= 2;
    end else if (bcnt != 0) begin
      bcnt <= bcnt - 1;
      if (bcnt == 1) ti_model <= 1'b1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One cycle; every launch is scored against the queue of written bytes.
  task automatic tick();
    @(negedge clock);
    if (WR === 1'b1) begin
      n_wr++;
      if (sb.size() == 0) begin
        n_vec++;
        n_miss++;
        $display("FAIL unexpected_wr: got dout %0h want no launch", dout);
      end else chk("dout_order", dout, sb.pop_front());
      chk("wr_spacing", wr_prev, 0);
    end
    if (wr_l === 1'b1) chk("lvl_no_wr", wr_l, 0);
    wr_prev = WR;
  endtask

  // Leaves en high at the negedge right after the write edge.
  task automatic wr_byte(input logic [7:0] d, input logic keep);
    din = d;
    en  = 1'b1;
    if (keep) sb.push_back(d);
    tick();
    tick();
  endtask

  task automatic wr_done();
    en = 1'b0;
    tick();
  endtask

  task automatic drain(input int budget);
    int k = 0;
    while ((sb.size() != 0 || !empty) && k < budget) begin
      tick();
      k++;
    end
    chk("drain_in_budget", (k < budget), 1);
    repeat (6) tick();
  endtask

  initial begin
    for (int i = 0; i < 17; i++) begin
      tbl[i].din  = 8'h60 + 8'(i);
      tbl[i].cnt  = (i < 16) ? 5'(i + 1) : 5'd16;
      tbl[i].full = (i >= 15);
      tbl[i].af   = (tbl[i].cnt >= 14);
      tbl[i].ovf  = (i == 16);
      tbl[i].kept = (i < 16);
    end
    rst = 1'b1; en = 0; din = 0; flush = 0; clr_err = 0; ti_man = 0; auto_ti = 0;
    en_l = 0; din_l = 0; flush_l = 0; clr_l = 0; ti_l = 0;
    repeat (3) tick();
    chk("rst_wr", WR, 0);     chk("rst_dout", dout, 0);   chk("rst_count", count, 0);
    chk("rst_empty", empty, 1); chk("rst_full", full, 0); chk("rst_af", af, 0);
    chk("rst_ovf", ovf, 0);   chk("rst_tmo", tmo, 0);
    rst = 1'b0;
    tick();

    // Three bytes through the UART model.
    auto_ti = 1'b1;
    base = n_wr;
    wr_byte(8'h41, 1);
    chk("t1_count", count, 1);
    chk("t1_wr_early", WR, 0);
    wr_done();
    chk("t1_launch_latency", WR, 1);
    wr_byte(8'h42, 1); wr_done();
    wr_byte(8'h43, 1); wr_done();
    drain(200);
    chk("t1_wr_count", n_wr - base, 3);
    chk("t1_count_end", count, 0);
    chk("t1_empty_end", empty, 1);

    // Fill past full with TI low.
    auto_ti = 1'b0;
    ti_man  = 1'b0;
    for (int i = 0; i < 17; i++) begin
      wr_byte(tbl[i].din, tbl[i].kept);
      chk("tbl_count", count, tbl[i].cnt);
      chk("tbl_full", full, tbl[i].full);
      chk("tbl_af", af, tbl[i].af);
      chk("tbl_ovf", ovf, tbl[i].ovf);
      wr_done();
    end
    base = n_wr;
    auto_ti = 1'b1;
    drain(400);
    chk("ovf_wr_count", n_wr - base, 16);
    chk("ovf_sticky", ovf, 1);
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    chk("ovf_clr", ovf, 0);

    // Push and pop on the same edge with count=3.
    auto_ti = 1'b0;
    ti_man  = 1'b0;
    wr_byte(8'h90, 1); wr_done();
    wr_byte(8'h91, 1); wr_done();
    wr_byte(8'h92, 1); wr_done();
    chk("pp_count_pre", count, 3);
    base = n_wr;
    din = 8'h93;
    en  = 1'b1;
    sb.push_back(8'h93);
    tick();
    ti_man = 1'b1;
    tick();
    chk("pp_count", count, 3);
    chk("pp_wr", WR, 1);
    ti_man = 1'b0;
    en     = 1'b0;
    tick();
    auto_ti = 1'b1;
    drain(200);
    chk("pp_wr_count", n_wr - base, 4);

    // Busy timeout with TI stuck high.
    auto_ti = 1'b0;
    ti_man  = 1'b0;
    wr_byte(8'hA1, 1); wr_done();
    wr_byte(8'hA2, 1); wr_done();
    ti_man = 1'b1;
    tick();
    chk("to_launch_a", WR, 1);
    repeat (7) tick();
    chk("to_not_yet", tmo, 0);
    tick();
    chk("to_set", tmo, 1);
    tick();
    chk("to_launch_b", WR, 1);
    chk("to_count", count, 0);
    ti_man = 1'b0;
    tick();
    ti_man = 1'b1;
    repeat (2) tick();
    chk("to_sticky", tmo, 1);
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    chk("to_clr", tmo, 0);

    // Reset in WAIT_IDLE with four bytes queued.
    ti_man = 1'b0;
    for (int i = 0; i < 5; i++) begin
      wr_byte(8'hC0 + 8'(i), 1);
      wr_done();
    end
    ti_man = 1'b1;
    tick();
    chk("rs_launch", WR, 1);
    ti_man = 1'b0;
    tick();
    chk("rs_count_pre", count, 4);
    rst    = 1'b1;
    ti_man = 1'b1;
    tick();
    chk("rs_wr", WR, 0);      chk("rs_dout", dout, 0);   chk("rs_count", count, 0);
    chk("rs_empty", empty, 1); chk("rs_full", full, 0);  chk("rs_af", af, 0);
    rst = 1'b0;
    sb.delete();
    base = n_wr;
    repeat (6) tick();
    chk("rs_no_wr", n_wr - base, 0);
    chk("rs_empty_after", empty, 1);

    // Level mode: five cycles of en, then flush.
    en_l  = 1'b1;
    din_l = 8'h5A;
    repeat (5) tick();
    en_l = 1'b0;
    repeat (2) tick();
    chk("lvl_count5", cnt_l, 5);
    flush_l = 1'b1;
    tick();
    flush_l = 1'b0;
    chk("lvl_flush_count", cnt_l, 0);
    chk("lvl_flush_empty", empty_l, 1);

    // Level mode fill, set-wins-over-clear, flush discarding a push.
    en_l = 1'b1;
    repeat (20) tick();
    chk("lvl_full_count", cnt_l, 16);
    chk("lvl_full", full_l, 1);
    chk("lvl_af", af_l, 1);
    chk("lvl_ovf", ovf_l, 1);
    clr_l = 1'b1;
    tick();
    clr_l = 1'b0;
    chk("lvl_set_wins", ovf_l, 1);
    flush_l = 1'b1;
    tick();
    chk("lvl_flush_push_count", cnt_l, 0);
    chk("lvl_flush_keeps_ovf", ovf_l, 1);
    en_l = 1'b0;
    repeat (2) tick();
    flush_l = 1'b0;
    clr_l   = 1'b1;
    tick();
    clr_l = 1'b0;
    chk("lvl_ovf_clr", ovf_l, 0);
    chk("lvl_end_count", cnt_l, 0);
    chk("lvl_end_empty", empty_l, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo_ctrl.md
# uart_tx_fifo_ctrl

Parametrised transmit-side buffer and sequencer for the UART path. Captures bytes from the host side on a write strobe, stores them in an internal FIFO, and releases them one at a time to the UART transmitter using the transmitter-idle (TI) handshake. It adds the following behaviour on top of the single-byte edge/idle control scheme:
- configurable width, depth and write mode
- overflow and busy-timeout reporting
- flush and an almost-full watermark

## Interface
Parameters:
- DATA_W, 8: data width in bits.
- DEPTH, 16: FIFO entries; power of two, at least 2.
- AF_LEVEL, DEPTH-2: almost_full asserts when count >= AF_LEVEL.
- EDGE_WR, 1: 1 = write on rising edge of synchronised en; 0 = write on every cycle en is high.
- BUSY_TO, 1023: cycles to wait for TI to fall after a launch; 0 disables the timeout.

Ports:
- clock in 1: single clock; all logic on its rising edge.
- rst in 1: synchronous, active-high reset.
- en in 1: write request; may be asynchronous; passes through a 2-flop synchroniser.
- din in DATA_W: write data; must be stable from en rise until the write edge.
- flush in 1: synchronous FIFO clear.
- clr_err in 1: clears overflow and timeout.
- TI in 1: transmitter idle, high when the UART can accept a byte.
- WR out 1: one-cycle launch strobe to the transmitter.
- dout out DATA_W: byte presented with WR; held until the next launch.
- full out 1: FIFO status.
- empty out 1: FIFO status.
- almost_full out 1: FIFO status.
- count out $clog2(DEPTH)+1: current occupancy.
- overflow out 1: sticky; a write was dropped because the FIFO was full.
- timeout out 1: sticky; TI did not fall within BUSY_TO cycles.

## Operation
- Reset values: WR=0, dout=0, count=0, empty=1, full=0, almost_full=0, overflow=0, timeout=0, tx FSM in IDLE, synchroniser flops 0. Reset mid-transfer abandons the transfer without issuing WR.
- Write path: en_s1<=en, en_s2<=en_s1. push_req = en_s1&~en_s2 when EDGE_WR=1, else en_s1.
  - push_req & !full: mem[wptr]<=din, wptr increments mod DEPTH.
  - push_req & full: data dropped, overflow<=1.
- Tx FSM, states IDLE, WAIT_BUSY, WAIT_IDLE:
  - IDLE: if TI & !empty, then WR<=1, dout<=mem[rptr], rptr increments, and the FSM moves to WAIT_BUSY. Otherwise it stays in IDLE.
  - WAIT_BUSY: if !TI, go to WAIT_IDLE. Otherwise tcnt increments. When BUSY_TO!=0 and tcnt==BUSY_TO-1: timeout<=1 and go to IDLE. tcnt clears on every entry to WAIT_BUSY.
  - WAIT_IDLE: if TI, go to IDLE; otherwise stay.
- count rules:
  - Push and pop on the same edge leave count unchanged.
  - full = (count==DEPTH), empty = (count==0).
  - Pointers are log2(DEPTH) bits and wrap naturally.
- flush: wptr, rptr and count go to 0, and any push on that edge is discarded. flush does not affect the tx FSM, dout or the error flags. A byte already launched completes normally.
- clr_err clears both flags. If an error event occurs on the same edge as clr_err, the flag sets; the set wins.

## Timing
- en rising between edges k-1 and k: en_s1=1 after k. The write occurs at edge k+1, so count and empty update after edge k+1.
- Write-to-launch latency with the FSM in IDLE and TI=1:
  - Data written at edge k+1.
  - FSM sees !empty and launches at edge k+2.
  - WR is high for the cycle after k+2.
- WR is never high for two consecutive cycles. The minimum spacing between launches is 3 cycles: launch, TI fall, TI rise.
- Level mode with en held high writes one entry per cycle until full. Every further cycle sets overflow.
- full is visible the cycle after the filling write, so a push on the following edge is dropped.

## Structure
- Package uart_fifo_pkg holds:
  - tx_state_t enum (IDLE, WAIT_BUSY, WAIT_IDLE)
  - the pointer and count width expressions derived from DEPTH
- Sub-module sync_fifo_mem is a DATA_W x DEPTH register array with a synchronous write port and a registered read at rptr.
- The top module contains the synchroniser, the pointer/count logic, the tx FSM and the error flags.

## Test plan
- Reset, then write 0x41, 0x42, 0x43 by toggling en with TI toggled by a UART model. Expect:
  - three WR pulses, dout 0x41, 0x42, 0x43 in order
  - count returns to 0 and empty=1
- Hold TI=0 and write DEPTH+1 bytes. Expect:
  - full=1, count=16
  - overflow=1 after the 17th write
  - the 17th byte is never transmitted
- EDGE_WR=0, en high 5 cycles, TI=0. Expect count=5. Then drive flush=1. Expect count=0, empty=1 and no WR.
- Launch one byte with TI held high for BUSY_TO cycles (BUSY_TO=8). Expect:
  - timeout=1 on the 8th cycle in WAIT_BUSY
  - FSM returns to IDLE and launches the next queued byte
- Push on the same edge as a pop with count=3. Expect count stays 3 and data order is preserved.
- Assert rst while in WAIT_IDLE with 4 bytes queued. Expect all outputs at reset values next cycle and no WR.
